deinterlace_source: RTL and testbench

Avalon-ST video transmitter for the deinterlacer: reads field lines that the sink has written into the two line buffers and emits a progressive frame. It sends a control packet, then a video packet in which each received field line is followed by a line interpolated from it and the next field line. It handshakes with the sink through ready_to_continue / aver_sent so that buffers are refilled while the source is still streaming.

---
 rtl/deinterlace_source_if.sv | 30 +++
 rtl/deinterlace_source.sv | 214 +++++++++++++++++++++
 tb/tb_deinterlace_source.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/deinterlace_source_if.sv
// rtl/deinterlace_source_if.sv - stream, line-buffer and sink-handshake signals of the deinterlacer source
interface deinterlace_source_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] dout_data;
  logic                  dout_valid;
  logic                  dout_ready;
  logic                  dout_startofpacket;
  logic                  dout_endofpacket;
  logic [DATA_WIDTH-1:0] q0;
  logic                  empty0;
  logic                  rd_req0;
  logic [DATA_WIDTH-1:0] q1;
  logic                  empty1;
  logic                  rd_req1;
  logic                  ready_to_continue;
  logic                  aver_sent;

  modport master (
    output dout_data, dout_valid, dout_startofpacket, dout_endofpacket,
    output rd_req0, rd_req1, aver_sent,
    input  dout_ready, q0, empty0, q1, empty1, ready_to_continue
  );

  modport slave (
    input  dout_data, dout_valid, dout_startofpacket, dout_endofpacket,
    input  rd_req0, rd_req1, aver_sent,
    output dout_ready, q0, empty0, q1, empty1, ready_to_continue
  );
endinterface

// File: rtl/deinterlace_source.sv
// rtl/deinterlace_source.sv - deinterlacer source: control packet, then field lines interleaved with averaged lines
// Optional macro LAST_LINE_DUP_EN repeats the final line so the output height is 2*HALF_HEIGHT.
module deinterlace_source #(
  parameter int DATA_WIDTH  = 8,
  parameter int WIDTH       = 720,
  parameter int HALF_HEIGHT = 288
) (
  input  logic                   clock,
  input  logic                   reset,
  deinterlace_source_if.master   src
);
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
`ifdef LAST_LINE_DUP_EN
  localparam int OUT_H = 2 * HALF_HEIGHT;
`else
  localparam int OUT_H = 2 * HALF_HEIGHT - 1;
`endif
  localparam logic [15:0] WIDTH_W   = 16'(WIDTH);
  localparam logic [15:0] OUT_H_W   = 16'(OUT_H);
  localparam logic [9:0]  LAST_PX   = 10'(WIDTH - 1);
  localparam logic [9:0]  LAST_LINE = 10'(HALF_HEIGHT - 2);

  typedef enum logic [2:0] {
    S_IDLE, S_CTRL, S_VHDR, S_FIRST, S_WAIT, S_AVG, S_NEWL
`ifdef LAST_LINE_DUP_EN
    , S_LAST
`endif
  } state_t;

  state_t                state_q, state_d;
  logic [9:0]            px_q, px_d;
  logic [9:0]            line_q, line_d;
  logic                  cur_buff_q, cur_buff_d;
  logic                  bank_sel_q, bank_sel_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  sop_q, sop_d;
  logic                  eop_q, eop_d;

  logic [DATA_WIDTH-1:0] bank0 [WIDTH];
  logic [DATA_WIDTH-1:0] bank1 [WIDTH];

  logic                  load;
  logic [IDX_W-1:0]      idx;
  logic [DATA_WIDTH-1:0] prev_rd, new_rd, cur_q, avg, ctrl_word, wr_data;
  logic [DATA_WIDTH:0]   avg_sum;
  logic                  cur_empty, pop0, pop1, aver, wr_prev, wr_new, wr0, wr1;

  assign load      = !valid_q || src.dout_ready;
  assign idx       = px_q[IDX_W-1:0];
  // bank_sel_q names the bank holding the previous output field line
  assign prev_rd   = bank_sel_q ? bank1[idx] : bank0[idx];
  assign new_rd    = bank_sel_q ? bank0[idx] : bank1[idx];
  assign cur_q     = cur_buff_q ? src.q1 : src.q0;
  assign cur_empty = cur_buff_q ? src.empty1 : src.empty0;
  assign avg_sum   = {1'b0, prev_rd} + {1'b0, cur_q} + (DATA_WIDTH + 1)'(1);
  assign avg       = avg_sum[DATA_WIDTH:1];

  always_comb begin
    ctrl_word = '0;
    case (px_q)
      10'd0:   ctrl_word[3:0] = 4'hF;
      10'd1:   ctrl_word[3:0] = WIDTH_W[15:12];
      10'd2:   ctrl_word[3:0] = WIDTH_W[11:8];
      10'd3:   ctrl_word[3:0] = WIDTH_W[7:4];
      10'd4:   ctrl_word[3:0] = WIDTH_W[3:0];
      10'd5:   ctrl_word[3:0] = OUT_H_W[15:12];
      10'd6:   ctrl_word[3:0] = OUT_H_W[11:8];
      10'd7:   ctrl_word[3:0] = OUT_H_W[7:4];
      10'd8:   ctrl_word[3:0] = OUT_H_W[3:0];
      default: ctrl_word[3:0] = 4'h0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    px_d       = px_q;
    line_d     = line_q;
    cur_buff_d = cur_buff_q;
    bank_sel_d = bank_sel_q;
    valid_d    = valid_q;
    data_d     = data_q;
    sop_d      = sop_q;
    eop_d      = eop_q;
    pop0       = 1'b0;
    pop1       = 1'b0;
    aver       = 1'b0;
    wr_prev    = 1'b0;
    wr_new     = 1'b0;
    wr_data    = cur_q;
    if (load) begin
      valid_d = 1'b0;
      sop_d   = 1'b0;
      eop_d   = 1'b0;
    end
    case (state_q)
      S_IDLE: if (!src.empty0) state_d = S_CTRL;
      S_CTRL: if (load) begin
        valid_d = 1'b1;
        data_d  = ctrl_word;
        sop_d   = (px_q == 10'd0);
        eop_d   = (px_q == 10'd9);
        if (px_q == 10'd9) begin
          px_d    = '0;
          state_d = S_VHDR;
        end else px_d = px_q + 10'd1;
      end
      S_VHDR: if (load) begin
        valid_d = 1'b1;
        data_d  = '0;
        sop_d   = 1'b1;
        state_d = S_FIRST;
      end
      S_FIRST: if (load && !src.empty0) begin
        pop0    = 1'b1;
        valid_d = 1'b1;
        data_d  = src.q0;
        wr_prev = 1'b1;
        wr_data = src.q0;
        if (px_q == LAST_PX) begin
          px_d       = '0;
          cur_buff_d = 1'b1;
          state_d    = S_WAIT;
        end else px_d = px_q + 10'd1;
      end
      S_WAIT: if (src.ready_to_continue) state_d = S_AVG;
      S_AVG: if (load && !cur_empty) begin
        pop0    = !cur_buff_q;
        pop1    = cur_buff_q;
        valid_d = 1'b1;
        data_d  = avg;
        wr_new  = 1'b1;
        if (px_q == LAST_PX) begin
          aver       = 1'b1;
          cur_buff_d = !cur_buff_q;
          px_d       = '0;
          state_d    = S_NEWL;
        end else px_d = px_q + 10'd1;
      end
      S_NEWL: if (load) begin
        valid_d = 1'b1;
        data_d  = new_rd;
        if (px_q == LAST_PX) begin
          px_d       = '0;
          bank_sel_d = !bank_sel_q;
          line_d     = line_q + 10'd1;
          if (line_q == LAST_LINE) begin
`ifdef LAST_LINE_DUP_EN
            state_d = S_LAST;
`else
            eop_d   = 1'b1;
            line_d  = '0;
            state_d = S_IDLE;
`endif
          end else state_d = S_WAIT;
        end else px_d = px_q + 10'd1;
      end
`ifdef LAST_LINE_DUP_EN
      // banks were just swapped, so the line to repeat now sits in the prev slot
      S_LAST: if (load) begin
        valid_d = 1'b1;
        data_d  = prev_rd;
        if (px_q == LAST_PX) begin
          eop_d   = 1'b1;
          px_d    = '0;
          line_d  = '0;
          state_d = S_IDLE;
        end else px_d = px_q + 10'd1;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      px_q       <= '0;
      line_q     <= '0;
      cur_buff_q <= 1'b0;
      bank_sel_q <= 1'b0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      sop_q      <= 1'b0;
      eop_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      px_q       <= px_d;
      line_q     <= line_d;
      cur_buff_q <= cur_buff_d;
      bank_sel_q <= bank_sel_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      sop_q      <= sop_d;
      eop_q      <= eop_d;
    end
  end

  assign wr0 = !reset && ((wr_prev && !bank_sel_q) || (wr_new && bank_sel_q));
  assign wr1 = !reset && ((wr_prev && bank_sel_q) || (wr_new && !bank_sel_q));

  always_ff @(posedge clock) begin
    if (wr0) bank0[idx] <= wr_data;
    if (wr1) bank1[idx] <= wr_data;
  end

  assign src.dout_data          = data_q;
  assign src.dout_valid         = valid_q;
  assign src.dout_startofpacket = sop_q;
  assign src.dout_endofpacket   = eop_q;
  assign src.rd_req0            = pop0 && !reset;
  assign src.rd_req1            = pop1 && !reset;
  assign src.aver_sent          = aver && !reset;
endmodule

// File: tb/tb_deinterlace_source.sv
// tb/tb_deinterlace_source.sv - directed bench for deinterlace_source, WIDTH=4, HALF_HEIGHT=3
module tb_deinterlace_source;
`ifdef LAST_LINE_DUP_EN
  localparam int OUT_H = 6;
  localparam int EXP_N = 35;
`else
  localparam int OUT_H = 5;
  localparam int EXP_N = 31;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  deinterlace_source_if #(.DATA_WIDTH(8)) bus ();

  deinterlace_source #(.DATA_WIDTH(8), .WIDTH(4), .HALF_HEIGHT(3)) dut (
    .clock (clock),
    .reset (reset),
    .src   (bus)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  logic [7:0] f0[$];
  logic [7:0] f1[$];
  logic [9:0] out_q[$];
  logic [9:0] exp_q[$];
  int aver_tot[$];
  int pops0 = 0, pops1 = 0, aver_cnt = 0, stall_left = 0;
  bit stall_done = 0;
  logic [7:0] tmp;
  logic [7:0] line0 [4] = '{8'd10, 8'd20, 8'd30, 8'd41};
  logic [7:0] line1 [4] = '{8'd11, 8'd20, 8'd255, 8'd0};
  logic [7:0] line2 [4] = '{8'd1, 8'd2, 8'd3, 8'd4};
  logic [7:0] avg1  [4] = '{8'd11, 8'd20, 8'd143, 8'd21};
  logic [7:0] avg2  [4] = '{8'd6, 8'd11, 8'd129, 8'd2};
  logic [7:0] ctrl  [10] = '{8'h0F, 8'h0, 8'h0, 8'h0, 8'h4, 8'h0, 8'h0, 8'h0, 8'(OUT_H), 8'h0};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive_fifo();
    bus.empty0 = (f0.size() == 0);
    bus.q0     = (f0.size() != 0) ? f0[0] : 8'h00;
    bus.empty1 = (f1.size() == 0);
    bus.q1     = (f1.size() != 0) ? f1[0] : 8'h00;
  endtask

  task automatic tick();
    bus.dout_ready = (stall_left == 0);
    #2;
    if (!reset && bus.dout_valid && bus.dout_ready)
      out_q.push_back({bus.dout_startofpacket, bus.dout_endofpacket, bus.dout_data});
    if (bus.rd_req0) begin
      check("rd0_nonempty", 32'(f0.size() != 0), 1);
      if (f0.size() != 0) tmp = f0.pop_front();
      pops0++;
    end
    if (bus.rd_req1) begin
      check("rd1_nonempty", 32'(f1.size() != 0), 1);
      if (f1.size() != 0) tmp = f1.pop_front();
      pops1++;
    end
    if (bus.aver_sent) begin
      aver_cnt++;
      aver_tot.push_back(pops0 + pops1);
      check("aver_with_pop", 32'(bus.rd_req0 | bus.rd_req1), 1);
    end
    if (stall_left > 0) begin
      check("stall_valid", 32'(bus.dout_valid), 1);
      check("stall_data", 32'(bus.dout_data), 20);
      check("stall_rdreq", 32'({bus.rd_req1, bus.rd_req0}), 0);
      stall_left--;
    end else if (!stall_done && pops1 == 2) begin
      stall_left = 5;
      stall_done = 1;
    end
    @(posedge clock);
    #1;
    drive_fifo();
  endtask

  task automatic run_until(input int n, input int bound, input string tag);
    int c = 0;
    while (out_q.size() < n && c < bound) begin
      tick();
      c++;
    end
    check(tag, out_q.size(), n);
  endtask

  task automatic push_line(input logic sop, input logic [7:0] px [4], input logic eop_last);
    for (int i = 0; i < 4; i++) exp_q.push_back({sop && i == 0, eop_last && i == 3, px[i]});
  endtask

  initial begin
    bus.dout_ready = 1'b1;
    bus.ready_to_continue = 1'b0;
    drive_fifo();
    repeat (3) @(posedge clock);
    #1;
    check("rst_valid", 32'(bus.dout_valid), 0);
    check("rst_sop", 32'(bus.dout_startofpacket), 0);
    check("rst_eop", 32'(bus.dout_endofpacket), 0);
    check("rst_data", 32'(bus.dout_data), 0);
    check("rst_rdreq", 32'({bus.rd_req1, bus.rd_req0}), 0);
    check("rst_aver", 32'(bus.aver_sent), 0);
    reset = 1'b0;

    for (int i = 0; i < 4; i++) begin
      f0.push_back(line0[i]);
      f1.push_back(line1[i]);
    end
    for (int i = 0; i < 4; i++) f0.push_back(line2[i]);
    drive_fifo();
    run_until(15, 200, "first_line_wait");
    check("first_pops0", pops0, 4);
    repeat (4) tick();
    check("wait_no_pop1", pops1, 0);
    check("wait_no_beat", out_q.size(), 15);
    bus.ready_to_continue = 1'b1;
    run_until(EXP_N, 400, "frame_wait");
    repeat (4) tick();

    for (int i = 0; i < 10; i++) exp_q.push_back({i == 0, i == 9, ctrl[i]});
    exp_q.push_back({1'b1, 1'b0, 8'h00});
    push_line(1'b0, line0, 1'b0);
    push_line(1'b0, avg1, 1'b0);
    push_line(1'b0, line1, 1'b0);
    push_line(1'b0, avg2, 1'b0);
`ifdef LAST_LINE_DUP_EN
    push_line(1'b0, line2, 1'b0);
    push_line(1'b0, line2, 1'b1);
`else
    push_line(1'b0, line2, 1'b1);
`endif
    check("frame_len", out_q.size(), EXP_N);
    for (int i = 0; i < EXP_N; i++)
      check($sformatf("beat%0d", i), (i < out_q.size()) ? 32'(out_q[i]) : 32'hFFFF, 32'(exp_q[i]));
    check("pops0_total", pops0, 8);
    check("pops1_total", pops1, 4);
    check("aver_count", aver_cnt, 2);
    check("aver1_at_pop", (aver_tot.size() > 0) ? aver_tot[0] : -1, 8);
    check("aver2_at_pop", (aver_tot.size() > 1) ? aver_tot[1] : -1, 12);
    check("stall_seen", 32'(stall_done), 1);

    out_q.delete();
    for (int i = 0; i < 4; i++) begin
      f0.push_back(line0[i]);
      f1.push_back(line1[i]);
    end
    for (int i = 0; i < 4; i++) f0.push_back(line2[i]);
    drive_fifo();
    run_until(21, 200, "newl_wait");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    f0.delete();
    f1.delete();
    drive_fifo();
    #1;
    check("abort_valid", 32'(bus.dout_valid), 0);
    check("abort_aver", 32'(bus.aver_sent), 0);
    check("abort_rdreq", 32'({bus.rd_req1, bus.rd_req0}), 0);
    check("abort_eop", 32'(bus.dout_endofpacket), 0);

    out_q.delete();
    for (int i = 0; i < 4; i++) f0.push_back(line0[i]);
    drive_fifo();
    run_until(10, 100, "ctrl2_wait");
    for (int i = 0; i < 10; i++)
      check($sformatf("ctrl2_%0d", i), (i < out_q.size()) ? 32'(out_q[i]) : 32'hFFFF,
            32'({i == 0, i == 9, ctrl[i]}));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
